// File: rtl/tile_sprite_scheduler.sv
// tile_sprite_scheduler: per-frame sprite scheduler for a 16x2 tile.
// Sprite commands are queued in a small FIFO. For each queued sprite the scheduler fetches its
// texture row-pair from memory and dispatches it to the stream-processor array. A frame starts
// with a one-cycle array clear and ends after the command flagged cmd_last has been dispatched.
// Optional statistics counters are built only when the macro TILE_SCHED_STATS_EN is defined;
// otherwise stat_sprites and stat_stalls are tied to zero.
module tile_sprite_scheduler #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_x,
    input  logic [7:0]        cmd_z,
    input  logic              cmd_last,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [255:0]      mem_rdata,
    output logic              sp_ena,
    output logic [3:0]        sp_start_x,
    output logic [7:0]        sp_position_z,
    output logic [255:0]      sp_texture_data,
    output logic              sp_clear_n,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       stat_sprites,
    output logic [15:0]       stat_stalls
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    // Entry layout: {last, z[7:0], x[3:0], addr[ADDR_W-1:0]}
    localparam int unsigned EntW = ADDR_W + 13;
    localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFetch,
        StDispatch,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Command FIFO state
    logic [EntW-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [EntW-1:0] fifo_mem_d [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    // Holds cmd_ready low until the first clock after reset is released
    logic            ready_en_q, ready_en_d;

    // Latched dispatch payload of the most recently popped command
    logic [3:0]      sp_x_q, sp_x_d;
    logic [7:0]      sp_z_q, sp_z_d;
    logic [255:0]    sp_tex_q, sp_tex_d;
    logic            last_q, last_d;

    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            start_accept;
    logic [EntW-1:0] push_entry;
    logic [EntW-1:0] head_entry;
    logic [ADDR_W-1:0] head_addr;
    logic [3:0]      head_x;
    logic [7:0]      head_z;
    logic            head_last;

    assign fifo_full  = (count_q == FullCnt);
    assign fifo_empty = (count_q == '0);

    assign head_entry = fifo_mem_q[rd_ptr_q];
    assign head_addr  = head_entry[ADDR_W-1:0];
    assign head_x     = head_entry[ADDR_W +: 4];
    assign head_z     = head_entry[ADDR_W+4 +: 8];
    assign head_last  = head_entry[ADDR_W+12];
    assign push_entry = {cmd_last, cmd_z, cmd_x, cmd_addr};

    // cmd_ready comes only from registered state, never from cmd_valid or a pop this cycle
    assign cmd_ready = ready_en_q && !fifo_full;
    assign push      = cmd_valid && cmd_ready;

    // A request is only outstanding in FETCH with something queued; acks elsewhere are dropped
    assign mem_req  = (state_q == StFetch) && !fifo_empty;
    assign mem_addr = mem_req ? head_addr : '0;
    assign pop      = mem_req && mem_ack;

    assign start_accept = (state_q == StIdle) && start;

    assign sp_ena          = (state_q == StDispatch);
    assign sp_start_x      = sp_x_q;
    assign sp_position_z   = sp_z_q;
    assign sp_texture_data = sp_tex_q;
    assign sp_clear_n      = (state_q != StClear);
    assign busy            = (state_q != StIdle);
    assign frame_done      = (state_q == StDone);

    // FIFO next-state: write at tail on push, advance head on pop, occupancy tracks the difference
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ready_en_d = 1'b1;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fifo_mem_q <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_en_q <= 1'b0;
        end else begin
            fifo_mem_q <= fifo_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_en_q <= ready_en_d;
        end
    end

    // Frame FSM next-state and payload capture on the acked fetch
    always_comb begin
        state_d  = state_q;
        sp_x_d   = sp_x_q;
        sp_z_d   = sp_z_q;
        sp_tex_d = sp_tex_q;
        last_d   = last_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                state_d = StFetch;
            end
            StFetch: begin
                if (pop) begin
                    state_d  = StDispatch;
                    sp_x_d   = head_x;
                    sp_z_d   = head_z;
                    sp_tex_d = mem_rdata;
                    last_d   = head_last;
                end
            end
            StDispatch: begin
                state_d = last_q ? StDone : StFetch;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM and dispatch payload registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            sp_x_q   <= '0;
            sp_z_q   <= '0;
            sp_tex_q <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sp_x_q   <= sp_x_d;
            sp_z_q   <= sp_z_d;
            sp_tex_q <= sp_tex_d;
            last_q   <= last_d;
        end
    end

`ifdef TILE_SCHED_STATS_EN
    logic [15:0] stat_sprites_q, stat_sprites_d;
    logic [15:0] stat_stalls_q, stat_stalls_d;

    // Saturating sprite/stall counters, cleared when a new frame is accepted
    always_comb begin
        stat_sprites_d = stat_sprites_q;
        stat_stalls_d  = stat_stalls_q;
        if (start_accept) begin
            stat_sprites_d = '0;
            stat_stalls_d  = '0;
        end else begin
            if (sp_ena && (stat_sprites_q != 16'hFFFF)) begin
                stat_sprites_d = stat_sprites_q + 16'd1;
            end
            if (mem_req && !mem_ack && (stat_stalls_q != 16'hFFFF)) begin
                stat_stalls_d = stat_stalls_q + 16'd1;
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_sprites_q <= '0;
            stat_stalls_q  <= '0;
        end else begin
            stat_sprites_q <= stat_sprites_d;
            stat_stalls_q  <= stat_stalls_d;
        end
    end

    assign stat_sprites = stat_sprites_q;
    assign stat_stalls  = stat_stalls_q;
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
    assign stat_sprites        = '0;
    assign stat_stalls         = '0;
`endif

endmodule

// File: tb/tb_tile_sprite_scheduler.sv
// tb_tile_sprite_scheduler: randomized and directed stimulus against a transaction-level model
// of the scheduler (command queue, frame phase, held dispatch payload, statistics).
module tb_tile_sprite_scheduler;

    localparam int unsigned Depth = 4;
    localparam int unsigned AddrW = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_x;
    logic [7:0]       cmd_z;
    logic             cmd_last;
    logic [AddrW-1:0] cmd_addr;
    logic             mem_req;
    logic [AddrW-1:0] mem_addr;
    logic             mem_ack;
    logic [255:0]     mem_rdata;
    logic             sp_ena;
    logic [3:0]       sp_start_x;
    logic [7:0]       sp_position_z;
    logic [255:0]     sp_texture_data;
    logic             sp_clear_n;
    logic             busy;
    logic             frame_done;
    logic [15:0]      stat_sprites;
    logic [15:0]      stat_stalls;

    always #5 clk = ~clk;

    tile_sprite_scheduler #(
        .FIFO_DEPTH(Depth),
        .ADDR_W    (AddrW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_x          (cmd_x),
        .cmd_z          (cmd_z),
        .cmd_last       (cmd_last),
        .cmd_addr       (cmd_addr),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .sp_ena         (sp_ena),
        .sp_start_x     (sp_start_x),
        .sp_position_z  (sp_position_z),
        .sp_texture_data(sp_texture_data),
        .sp_clear_n     (sp_clear_n),
        .busy           (busy),
        .frame_done     (frame_done),
        .stat_sprites   (stat_sprites),
        .stat_stalls    (stat_stalls)
    );

    typedef struct packed {
        logic             last;
        logic [7:0]       z;
        logic [3:0]       x;
        logic [AddrW-1:0] addr;
    } cmd_t;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: queued commands, frame phase flags, held payload, statistics
    cmd_t         m_fifo[$];
    cmd_t         m_disp_cmd;
    bit           m_init, m_busy, m_clear, m_fetch, m_disp, m_done;
    logic [3:0]   m_x;
    logic [7:0]   m_z;
    logic [255:0] m_tex;
    int           m_sprites, m_stalls;

    // Memory responder controls
    int ack_lat   = 1;
    int wait_cnt  = 0;
    bit stray_en  = 0;
    bit ack_force = 0;

    bit pushed_last;
    int obs_disp, obs_clear, obs_done, obs_req;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_init    = 0;
        m_busy    = 0;
        m_clear   = 0;
        m_fetch   = 0;
        m_disp    = 0;
        m_done    = 0;
        m_x       = '0;
        m_z       = '0;
        m_tex     = '0;
        m_sprites = 0;
        m_stalls  = 0;
    endtask

    task automatic clear_obs();
        obs_disp  = 0;
        obs_clear = 0;
        obs_done  = 0;
        obs_req   = 0;
    endtask

    // One clock: compare outputs with the model, answer memory, advance the model across the edge
    task automatic cycle();
        bit   exp_ready, exp_req, popped, n_busy, n_clear, n_fetch, n_disp, n_done;
        cmd_t in_cmd;
        exp_ready = m_init && (m_fifo.size() < Depth);
        exp_req   = m_fetch && (m_fifo.size() > 0);

        check("cmd_ready", cmd_ready, exp_ready);
        check("mem_req", mem_req, exp_req);
        if (exp_req) check("mem_addr", mem_addr, m_fifo[0].addr);
        check("busy", busy, m_busy);
        check("sp_clear_n", sp_clear_n, !m_clear);
        check("sp_ena", sp_ena, m_disp);
        check("frame_done", frame_done, m_done);
        check("sp_start_x", sp_start_x, m_x);
        check("sp_position_z", sp_position_z, m_z);
        check("sp_texture_data", sp_texture_data, m_tex);
`ifdef TILE_SCHED_STATS_EN
        check("stat_sprites", stat_sprites, 16'(m_sprites));
        check("stat_stalls", stat_stalls, 16'(m_stalls));
`else
        check("stat_sprites", stat_sprites, 16'h0);
        check("stat_stalls", stat_stalls, 16'h0);
`endif
        if (sp_ena === 1'b1) obs_disp++;
        if (sp_clear_n === 1'b0) obs_clear++;
        if (frame_done === 1'b1) obs_done++;
        if (mem_req === 1'b1) obs_req++;

        // Memory side: ack on the ack_lat-th requesting cycle, optional stray acks otherwise
        if (exp_req) begin
            mem_ack  = ((wait_cnt + 1) >= ack_lat);
            wait_cnt = mem_ack ? 0 : wait_cnt + 1;
        end else begin
            mem_ack  = stray_en && ($urandom_range(0, 3) == 0);
            wait_cnt = 0;
        end
        if (ack_force) mem_ack = 1'b1;
        for (int i = 0; i < 8; i++) mem_rdata[i*32 +: 32] = $urandom();

        pushed_last = 0;
        if (!reset_n) begin
            model_reset();
        end else begin
            in_cmd      = '{last: cmd_last, z: cmd_z, x: cmd_x, addr: cmd_addr};
            pushed_last = cmd_valid && exp_ready;
            popped      = exp_req && mem_ack;
            if (exp_req && !mem_ack && m_stalls < 65535) m_stalls++;
            if (m_disp && m_sprites < 65535) m_sprites++;
            n_busy  = m_busy;
            n_clear = 0;
            n_fetch = m_fetch;
            n_disp  = 0;
            n_done  = 0;
            if (!m_busy) begin
                if (start) begin
                    n_busy    = 1;
                    n_clear   = 1;
                    m_sprites = 0;
                    m_stalls  = 0;
                end
            end else if (m_clear) begin
                n_fetch = 1;
            end else if (popped) begin
                n_fetch    = 0;
                n_disp     = 1;
                m_disp_cmd = m_fifo[0];
                m_x        = m_fifo[0].x;
                m_z        = m_fifo[0].z;
                m_tex      = mem_rdata;
            end else if (m_disp) begin
                if (m_disp_cmd.last) n_done = 1;
                else n_fetch = 1;
            end else if (m_done) begin
                n_busy = 0;
            end
            if (popped) void'(m_fifo.pop_front());
            if (pushed_last) m_fifo.push_back(in_cmd);
            m_init  = 1;
            m_busy  = n_busy;
            m_clear = n_clear;
            m_fetch = n_fetch;
            m_disp  = n_disp;
            m_done  = n_done;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [3:0] x, input logic [7:0] z, input logic last,
                            input logic [AddrW-1:0] addr);
        bit ok;
        ok        = 0;
        cmd_valid = 1'b1;
        cmd_x     = x;
        cmd_z     = z;
        cmd_last  = last;
        cmd_addr  = addr;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (pushed_last) begin
                ok = 1;
                break;
            end
        end
        cmd_valid = 1'b0;
        check("push_timeout", ok, 1'b1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound && m_busy; i++) cycle();
        check("idle_timeout", busy, 1'b0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        cmd_valid = 1'b0;
        cmd_x     = '0;
        cmd_z     = '0;
        cmd_last  = 1'b0;
        cmd_addr  = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        model_reset();
        clear_obs();
        @(posedge clk);
        #1;

        // Reset state, then cmd_ready rises one cycle after release
        run(2);
        check("rst_mem_addr", mem_addr, '0);
        reset_n = 1'b1;
        run(2);

        // Three-sprite frame with single-cycle ack
        clear_obs();
        push_cmd(4'd0, 8'd1, 1'b0, 16'($urandom()));
        push_cmd(4'd5, 8'd2, 1'b0, 16'($urandom()));
        push_cmd(4'd15, 8'd3, 1'b1, 16'($urandom()));
        pulse_start();
        wait_idle(100);
        check("f1_clears", obs_clear, 1);
        check("f1_dispatches", obs_disp, 3);
        check("f1_done", obs_done, 1);
`ifdef TILE_SCHED_STATS_EN
        check("f1_stat_sprites", stat_sprites, 16'd3);
`endif

        // Fill the FIFO with no frame running, then drain it through a frame
        for (int i = 0; i < Depth; i++) begin
            push_cmd(4'($urandom()), 8'($urandom()), (i == Depth - 1), 16'($urandom()));
        end
        check("full_ready", cmd_ready, 1'b0);
        ack_lat = 2;
        clear_obs();
        pulse_start();
        wait_idle(200);
        check("full_dispatches", obs_disp, Depth);

        // Slow memory: five requesting cycles per fetch
        ack_lat = 5;
        clear_obs();
        push_cmd(4'd3, 8'd9, 1'b0, 16'h1234);
        push_cmd(4'd7, 8'd4, 1'b1, 16'hBEEF);
        pulse_start();
        wait_idle(200);
        check("slow_dispatches", obs_disp, 2);
`ifdef TILE_SCHED_STATS_EN
        check("slow_stat_stalls", stat_stalls, 16'd8);
`endif

        // Start on an empty FIFO; the only command arrives later
        ack_lat = 1;
        clear_obs();
        pulse_start();
        run(10);
        check("empty_no_req", obs_req, 0);
        push_cmd(4'd2, 8'd2, 1'b1, 16'h0F0F);
        wait_idle(100);
        check("empty_done", obs_done, 1);

        // Reset while a fetch is outstanding, followed by a stray ack
        ack_lat = 100;
        clear_obs();
        push_cmd(4'd1, 8'd1, 1'b0, 16'hAAAA);
        push_cmd(4'd2, 8'd2, 1'b1, 16'h5555);
        pulse_start();
        run(4);
        check("rst_fetch_req", mem_req, 1'b1);
        reset_n = 1'b0;
        cycle();
        reset_n   = 1'b1;
        ack_force = 1'b1;
        cycle();
        ack_force = 1'b0;
        run(3);
        check("rst_fetch_disp", obs_disp, 0);
        check("rst_fetch_busy", busy, 1'b0);
        ack_lat = 1;
        clear_obs();
        pulse_start();
        run(3);
        check("rst_fifo_empty", obs_req, 0);
        push_cmd(4'd9, 8'd9, 1'b1, 16'h7777);
        wait_idle(100);

        // Repeated start while busy must not restart the frame
        ack_lat = 3;
        push_cmd(4'd4, 8'd4, 1'b0, 16'h0101);
        push_cmd(4'd6, 8'd6, 1'b1, 16'h0202);
        clear_obs();
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            start = m_busy && (i % 2 == 1);
            cycle();
            if (!m_busy) break;
        end
        start = 1'b0;
        check("restart_clears", obs_clear, 1);
        check("restart_done", obs_done, 1);

        // Random traffic with stray acks, random starts and occasional resets
        stray_en = 1;
        for (int i = 0; i < 1500; i++) begin
            if (i % 50 == 0) ack_lat = $urandom_range(1, 4);
            reset_n   = ($urandom_range(0, 299) != 0);
            cmd_valid = $urandom_range(0, 1);
            cmd_x     = 4'($urandom());
            cmd_z     = 8'($urandom());
            cmd_last  = ($urandom_range(0, 3) == 0);
            cmd_addr  = 16'($urandom());
            start     = ($urandom_range(0, 7) == 0);
            cycle();
        end
        reset_n   = 1'b1;
        start     = 1'b0;
        cmd_valid = 1'b0;
        ack_lat   = 1;
        run(2);
        if (m_busy) push_cmd(4'd8, 8'd8, 1'b1, 16'hC0DE);
        wait_idle(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/tile_sprite_scheduler.md
TILE_SPRITE_SCHEDULER -- requirements
Module: tile_sprite_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command FIFO entries (power of two, 2..16).
REQ-002 Parameter ADDR_W, default 16, texture memory address width.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  one-cycle pulse beginning a frame for the 16x2 tile.
REQ-006 cmd_valid, cmd_ready  in/out  1/1  sprite command handshake; transfer when both high.
REQ-007 cmd_x  in  4  sprite start column; cmd_z  in  8  sprite depth; cmd_last  in  1  final sprite of frame.
REQ-008 cmd_addr  in  ADDR_W  texture row-pair address.
REQ-009 mem_req  out  1  texture read request; mem_addr  out  ADDR_W  address held while mem_req high.
REQ-010 mem_ack  in  1  read complete; mem_rdata  in  256  texture data, valid in the mem_ack cycle.
REQ-011 sp_ena, sp_start_x[3:0], sp_position_z[7:0], sp_texture_data[255:0]  out  dispatch bus to the stream-processor array.
REQ-012 sp_clear_n  out  1  active-low one-cycle array clear.
REQ-013 busy  out  1  high from start acceptance until frame_done; frame_done  out  1  one-cycle pulse.
REQ-014 stat_sprites[15:0], stat_stalls[15:0]  out  statistics (see Configuration).

Function
REQ-015 Commands SHALL enter a FIFO; cmd_ready = FIFO not full, registered-state-derived, no bypass path.
REQ-016 Simultaneous push and pop SHALL leave occupancy unchanged; push when full or pop when empty SHALL never occur.
REQ-017 Commands SHALL be accepted in every state, including IDLE.
REQ-018 FSM states: IDLE, CLEAR, FETCH, DISPATCH, DONE.
REQ-019 IDLE: start sampled high -> CLEAR; busy high from next cycle.
REQ-020 CLEAR: sp_clear_n low for exactly one cycle -> FETCH.
REQ-021 FETCH: FIFO empty -> hold with mem_req low; nonempty -> mem_req high, mem_addr = head cmd_addr, until mem_ack.
REQ-022 mem_ack in FETCH with mem_req high: latch mem_rdata, pop head -> DISPATCH; mem_ack at any other time SHALL be ignored.
REQ-023 DISPATCH: sp_ena high exactly one cycle with latched data, cmd_x, cmd_z of popped entry; next FETCH or, if cmd_last, DONE.
REQ-024 Latency: mem_ack in cycle N -> sp_ena in N+1 -> next mem_req earliest N+2.
REQ-025 DONE: frame_done high one cycle, busy low from following cycle -> IDLE.
REQ-026 start while busy SHALL be ignored.
REQ-027 sp_start_x, sp_position_z, sp_texture_data SHALL hold their last values while sp_ena low.
REQ-028 Dispatch order SHALL equal acceptance order; depth ordering is the array's responsibility.

Reset
REQ-029 reset_n low: state IDLE, FIFO empty, mem_req 0, sp_ena 0, sp_clear_n 1, busy 0, frame_done 0, all data outputs 0, statistics 0.
REQ-030 Reset mid-fetch SHALL drop mem_req next cycle; a later stray mem_ack SHALL be ignored.
REQ-031 cmd_ready SHALL be low during reset and go high the cycle after reset_n rises.

Configuration
REQ-032 Macro TILE_SCHED_STATS_EN defined: stat_sprites counts sp_ena pulses, stat_stalls counts cycles with mem_req high and mem_ack low; both saturate at 0xFFFF and clear on start acceptance.
REQ-033 Macro undefined: counters absent, stat_sprites and stat_stalls tied to 0; all other behaviour identical.

Verification
REQ-034 Push 3 cmds (x=0,5,15; z=1,2,3; last on third), start, ack 1-cycle latency -> sp_clear_n low once, 3 sp_ena pulses in order, frame_done once, stat_sprites=3 if enabled.
REQ-035 Push FIFO_DEPTH cmds without start -> cmd_ready low; pop one -> cmd_ready high next cycle.
REQ-036 mem_ack delayed 5 cycles -> mem_addr stable throughout, stat_stalls=4 per fetch if enabled, sp_ena one cycle after ack.
REQ-037 start with empty FIFO, push last cmd 10 cycles later -> mem_req only after push, frame_done after its dispatch.
REQ-038 reset_n low during FETCH, then mem_ack pulse -> no sp_ena, FIFO empty, busy 0.
REQ-039 start pulsed while busy -> no second clear, single frame_done.
